// File: rtl/ula_arbiter.sv
// Round-robin arbiter that shares one combinational ULA among four requesters.
// Latency: WAIT_CYCLES+1 cycles from grant to req_done (1 cycle for a rejected opcode).
// Backpressure: a requester holds req_valid and operands until its req_done pulse; one request in service at a time.
//
// Optional feature: define ULA_ARB_OPCHECK_EN to reject opcodes 4'b0000 and 4'b1101
// without touching the ULA (req_err pulses with req_done, result/flags forced to zero).
//
// Ports:
//   clk, reset_n          single clock, asynchronous active-low reset
//   req_valid[3:0]        per-requester request, bit i = requester i
//   req_op[15:0]          opcode of requester i at [4i+3:4i]
//   req_a/req_b[31:0]     operands of requester i at [8i+7:8i]
//   req_done[3:0]         one-cycle completion pulse for the served requester
//   req_err[3:0]          rejected-opcode indication, valid with req_done
//   rsp_result/rsp_flags  shared result and {V,C,S,Z}, valid while req_done is high
//   ula_operation/ula_operand1/ula_operand2   registered drive of the shared ULA
//   ula_result/ula_flags  combinational ULA outputs
//   busy, grant_id        arbiter occupied / index of the requester being served

module ula_arbiter #(
   parameter int WAIT_CYCLES = 2   // ULA settle time in cycles, legal range 1..7
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [3:0]  req_valid,
   input  logic [15:0] req_op,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   output logic [3:0]  req_done,
   output logic [3:0]  req_err,
   output logic [7:0]  rsp_result,
   output logic [3:0]  rsp_flags,
   output logic [3:0]  ula_operation,
   output logic [7:0]  ula_operand1,
   output logic [7:0]  ula_operand2,
   input  logic [7:0]  ula_result,
   input  logic [3:0]  ula_flags,
   output logic        busy,
   output logic [1:0]  grant_id
);

   // Counter reload value; the ULA sees stable operands for WAIT_CYCLES cycles
   // (the load cycle's successor counts down to zero, then the result is captured).
   localparam logic [2:0] WAIT_LOAD = 3'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state;
   logic [1:0]  rr_ptr;     // first requester to consider at the next grant
   logic [2:0]  wait_cnt;

   // ------------------------------------------------------------------
   // Round-robin selection: first set bit at or above rr_ptr, wrapping 3->0.
   // Scanning from the farthest offset down lets the nearest one win.
   // ------------------------------------------------------------------
   logic        sel_vld;
   logic [1:0]  sel_idx;
   logic [1:0]  cand;

   always_comb begin
      sel_vld = 1'b0;
      sel_idx = rr_ptr;
      cand    = rr_ptr;
      for (int k = 3; k >= 0; k--) begin
         cand = rr_ptr + 2'(k);
         if (req_valid[cand]) begin
            sel_vld = 1'b1;
            sel_idx = cand;
         end
      end
   end

   // Fields of the selected requester.
   logic [3:0]  sel_op;
   logic [7:0]  sel_a;
   logic [7:0]  sel_b;
   logic [3:0]  sel_onehot;

   assign sel_op     = req_op[{sel_idx, 2'b00} +: 4];
   assign sel_a      = req_a[{sel_idx, 3'b000} +: 8];
   assign sel_b      = req_b[{sel_idx, 3'b000} +: 8];
   assign sel_onehot = 4'b0001 << sel_idx;

`ifdef ULA_ARB_OPCHECK_EN
   logic op_reject;
   assign op_reject = (sel_op == 4'b0000) || (sel_op == 4'b1101);
`else
   // Every opcode goes to the ULA; nothing is ever rejected.
   assign req_err = 4'b0000;
`endif

   // ------------------------------------------------------------------
   // Control FSM. All outputs are registered here; req_done/req_err are
   // cleared every cycle and set only on the transition into RESP, which
   // makes them exactly one cycle wide.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         rr_ptr        <= 2'd0;
         wait_cnt      <= 3'd0;
         req_done      <= 4'b0000;
`ifdef ULA_ARB_OPCHECK_EN
         req_err       <= 4'b0000;
`endif
         rsp_result    <= 8'h00;
         rsp_flags     <= 4'h0;
         ula_operation <= 4'h0;
         ula_operand1  <= 8'h00;
         ula_operand2  <= 8'h00;
         busy          <= 1'b0;
         grant_id      <= 2'd0;
      end else begin
         req_done <= 4'b0000;
`ifdef ULA_ARB_OPCHECK_EN
         req_err  <= 4'b0000;
`endif
         case (state)
            IDLE: begin
               if (sel_vld) begin
                  grant_id <= sel_idx;
                  busy     <= 1'b1;
`ifdef ULA_ARB_OPCHECK_EN
                  if (op_reject) begin
                     // Rejected opcode: answer next cycle, leave the ULA drive alone.
                     state      <= RESP;
                     req_done   <= sel_onehot;
                     req_err    <= sel_onehot;
                     rsp_result <= 8'h00;
                     rsp_flags  <= 4'h0;
                  end else begin
                     state         <= WAIT;
                     wait_cnt      <= WAIT_LOAD;
                     ula_operation <= sel_op;
                     ula_operand1  <= sel_a;
                     ula_operand2  <= sel_b;
                  end
`else
                  state         <= WAIT;
                  wait_cnt      <= WAIT_LOAD;
                  ula_operation <= sel_op;
                  ula_operand1  <= sel_a;
                  ula_operand2  <= sel_b;
`endif
               end
            end

            WAIT: begin
               if (wait_cnt == 3'd0) begin
                  // ULA has settled: capture and announce completion.
                  rsp_result <= ula_result;
                  rsp_flags  <= ula_flags;
                  req_done   <= 4'b0001 << grant_id;
                  state      <= RESP;
               end else begin
                  wait_cnt <= wait_cnt - 3'd1;
               end
            end

            RESP: begin
               // Requester after the one just served gets first look next time.
               rr_ptr <= grant_id + 2'd1;
               busy   <= 1'b0;
               state  <= IDLE;
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
